// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC-to-memory bridge: read FSM encoding and
// write-FIFO entry sizing.
package fsmc_pkg;

  typedef enum logic [2:0] {
    R_IDLE  = 3'd0,
    R_DRAIN = 3'd1,
    R_REQ   = 3'd2,
    R_WAIT  = 3'd3,
    R_HOLD  = 3'd4
  } rd_state_t;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

  // A FIFO entry is {address, data, byte enables}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

  localparam int DEF_EW = entry_width(DEF_AW, DEF_DW);

endpackage

// File: rtl/fsmc_wfifo.sv
// Write-posting FIFO. A push on a full FIFO succeeds only when a pop
// happens in the same cycle; otherwise the caller sees full and drops.
module fsmc_wfifo
  import fsmc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int EW    = DEF_EW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [EW-1:0]            wdata,
  input  logic                     pop,
  output logic [EW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  // NOTE: the data array is deliberately not reset -- only pointers and count
  // define validity, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsmc_bridge.sv
// FSMC async-host to valid/ready memory bridge. Writes are posted through a
// FIFO; reads drain the FIFO first so they observe every earlier write.
module fsmc_bridge
  import fsmc_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int DEPTH  = 4,
  parameter int SYNC   = 2,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          fsmc_a,
  input  logic [DW-1:0]          fsmc_d_i,
  output logic [DW-1:0]          fsmc_d_o,
  output logic                   fsmc_d_oe,
  input  logic                   fsmc_ne,
  input  logic                   fsmc_nwe,
  input  logic                   fsmc_noe,
  input  logic [DW/8-1:0]        fsmc_nbl,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_we,
  output logic [AW-1:0]          req_addr,
  output logic [DW-1:0]          req_wdata,
  output logic [DW/8-1:0]        req_be,
  input  logic                   rsp_valid,
  input  logic [DW-1:0]          rsp_rdata,
  output logic                   wr_ovf,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int BW = DW / 8;
  localparam int EW = entry_width(AW, DW);
  localparam int CW = $clog2(SETTLE + 1);

  logic [SYNC-1:0] ne_sync, nwe_sync, noe_sync;
  logic            ne_s, nwe_s, noe_s;
  logic            wr_low, rd_low, wr_armed, wr_accept, rd_accept;
  logic [CW-1:0]   wr_cnt, rd_cnt;
  logic [AW-1:0]   rd_addr;
  logic [EW-1:0]   head;
  logic            fifo_full, fifo_empty, fifo_pop;
  rd_state_t       state, state_nxt;

  // Strobe synchronisers; reset to 1 so strobes read as inactive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ne_sync  <= '1;
      nwe_sync <= '1;
      noe_sync <= '1;
    end else begin
      ne_sync  <= {ne_sync[SYNC-2:0], fsmc_ne};
      nwe_sync <= {nwe_sync[SYNC-2:0], fsmc_nwe};
      noe_sync <= {noe_sync[SYNC-2:0], fsmc_noe};
    end
  end

  assign ne_s   = ne_sync[SYNC-1];
  assign nwe_s  = nwe_sync[SYNC-1];
  assign noe_s  = noe_sync[SYNC-1];
  assign wr_low = !ne_s && !nwe_s;
  assign rd_low = !ne_s && !noe_s;

  assign wr_accept = wr_low && wr_armed && (wr_cnt == CW'(SETTLE - 1));
  assign rd_accept = rd_low && (state == R_IDLE) && (rd_cnt == CW'(SETTLE - 1));

  // Write strobe qualifier: one acceptance per strobe, re-armed on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt   <= '0;
      wr_armed <= 1'b1;
    end else if (!wr_low) begin
      wr_cnt   <= '0;
      wr_armed <= 1'b1;
    end else if (wr_accept) begin
      wr_cnt   <= '0;
      wr_armed <= 1'b0;
    end else if (wr_armed) begin
      wr_cnt   <= wr_cnt + 1'b1;
    end
  end

  // Read strobe qualifier and address capture; only counts while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_addr <= '0;
    end else if (!rd_low || state != R_IDLE) begin
      rd_cnt  <= '0;
    end else if (rd_accept) begin
      rd_cnt  <= '0;
      rd_addr <= fsmc_a;
    end else begin
      rd_cnt  <= rd_cnt + 1'b1;
    end
  end

  fsmc_wfifo #(.DEPTH(DEPTH), .EW(EW)) u_wfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_accept),
    .wdata ({fsmc_a, fsmc_d_i, ~fsmc_nbl}),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_pop = req_valid && req_ready && (state != R_REQ);

  // Sticky overflow: a write hit a full FIFO with no pop to make room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wr_ovf <= 1'b0;
    else if (wr_accept && fifo_full && !fifo_pop) wr_ovf <= 1'b1;
  end

  // Read FSM state register and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      fsmc_d_o <= '0;
    end else begin
      state <= state_nxt;
      if (state == R_WAIT && rsp_valid) fsmc_d_o <= rsp_rdata;
    end
  end

  // Read FSM next state and request mux (read request overrides FIFO head).
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_valid = !fifo_empty;
    req_we    = 1'b1;
    req_addr  = head[EW-1 -: AW];
    req_wdata = head[BW +: DW];
    req_be    = head[BW-1:0];
    case (state)
      R_IDLE:  if (rd_accept) state_nxt = R_DRAIN;
      R_DRAIN: if (fifo_empty && !fifo_pop) state_nxt = R_REQ;
      R_REQ: begin
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = rd_addr;
        req_wdata = '0;
        req_be    = '1;
        if (req_ready) state_nxt = R_WAIT;
      end
      R_WAIT:  if (rsp_valid) state_nxt = R_HOLD;
      R_HOLD:  if (noe_s || ne_s) state_nxt = R_IDLE;
      default: state_nxt = R_IDLE;
    endcase
  end

  assign fsmc_d_oe = !ne_s && !noe_s && nwe_s;

endmodule
